// File: rtl/tdisp_pkg.sv
// Shared types, width helpers and conversion constants for the sequential
// temperature display path.
package tdisp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int C_MUL = 10;
   localparam int F_MUL = 18;
   localparam int F_OFS = 320;

   function automatic int tx_w(input int tc_w);
      return tc_w + 5;
   endfunction

   function automatic int mag_w(input int tc_w);
      return tx_w(tc_w) - 1;
   endfunction

   function automatic int mr_w(input int tc_w, input int frac);
      return mag_w(tc_w) - frac;
   endfunction

endpackage

// File: rtl/dbl_dabble_seq.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per clock.
// done flags the cycle whose closing edge performs the final shift.
module dbl_dabble_seq #(
   parameter int IN_W = 13,
   parameter int NBCD = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [IN_W-1:0]   value,
   output logic              busy,
   output logic              done,
   output logic [4*NBCD-1:0] bcd
);

   localparam int CNT_W = $clog2(IN_W + 1);

   logic [IN_W-1:0]   sr_r;
   logic [4*NBCD-1:0] acc_r;
   logic [4*NBCD-1:0] adj_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              busy_r;

   // Add 3 to every nibble that would reach 10 or more after the shift.
   always_comb begin
      adj_s = acc_r;
      for (int i = 0; i < NBCD; i++) begin
         if (acc_r[4*i +: 4] >= 4'd5) begin
            adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = acc_r[4*i +: 4];
         end
      end
   end

   // Load, then shift accumulator and source register left together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_r   <= '0;
         acc_r  <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
      end else if (load) begin
         sr_r   <= value;
         acc_r  <= '0;
         cnt_r  <= CNT_W'(IN_W);
         busy_r <= 1'b1;
      end else if (busy_r) begin
         acc_r  <= (adj_s << 1) | {{(4*NBCD-1){1'b0}}, sr_r[IN_W-1]};
         sr_r   <= sr_r << 1;
         cnt_r  <= cnt_r - CNT_W'(1);
         busy_r <= (cnt_r != CNT_W'(1));
      end else begin
         busy_r <= 1'b0;
      end
   end

   assign busy = busy_r;
   assign done = busy_r && (cnt_r == CNT_W'(1));
   assign bcd  = acc_r;

endmodule

// File: rtl/tdisplay_seq.sv
// Sequential temperature display path: signed fixed-point Celsius in,
// rounded sign-magnitude BCD tenths out (C or F), with overflow saturation.
module tdisplay_seq #(
   parameter int TC_W = 13,
   parameter int FRAC = 4,
   parameter int NDIG = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic signed [TC_W-1:0] tc,
   input  logic                   c_f,
   output logic                   ready,
   output logic                   done,
   output logic                   sign,
   output logic [4*NDIG-1:0]      digits,
   output logic                   ovf
);

   import tdisp_pkg::*;

   localparam int TX_W  = tx_w(TC_W);
   localparam int MAG_W = mag_w(TC_W);
   localparam int MR_W  = mr_w(TC_W, FRAC);
   localparam int NBCD  = NDIG + 1;
   localparam int HALF  = 1 << (FRAC - 1);

   state_t state_r, state_next_s;

   logic signed [TC_W-1:0] tc_r;
   logic                   c_f_r;
   logic                   neg_r;
   logic                   mr_nz_r;
   logic                   ready_r;
   logic                   done_r;
   logic                   sign_r;
   logic [4*NDIG-1:0]      digits_r;
   logic                   ovf_r;

   logic signed [TX_W-1:0] tc_ext_s;
   logic signed [TX_W-1:0] tx10_s;
   logic signed [TX_W-1:0] abs_s;
   logic                   neg_s;
   logic [MAG_W-1:0]       mag_s;
   logic [MAG_W-1:0]       rsum_s;
   logic [MR_W-1:0]        mr_s;
   logic                   load_s;
   logic                   eng_busy_s;
   logic                   eng_done_s;
   logic [4*NBCD-1:0]      eng_bcd_s;
   logic                   ovf_s;

   // Scale to tenths, take magnitude and round half away from zero.
   always_comb begin
      tc_ext_s = TX_W'(tc_r);
      if (c_f_r) begin
         tx10_s = tc_ext_s * $signed(TX_W'(F_MUL)) + $signed(TX_W'(F_OFS << FRAC));
      end else begin
         tx10_s = tc_ext_s * $signed(TX_W'(C_MUL));
      end
      neg_s  = tx10_s[TX_W-1];
      abs_s  = neg_s ? -tx10_s : tx10_s;
      mag_s  = MAG_W'(abs_s);
      rsum_s = mag_s + MAG_W'(HALF);
      mr_s   = MR_W'(rsum_s >> FRAC);
   end

   assign ovf_s = |eng_bcd_s[4*NBCD-1:4*NDIG];

   dbl_dabble_seq #(
      .IN_W (MR_W),
      .NBCD (NBCD)
   ) u_dd (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s),
      .value (mr_s),
      .busy  (eng_busy_s),
      .done  (eng_done_s),
      .bcd   (eng_bcd_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; an idle engine while shifting means a lost run, so recover to IDLE.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = CONV;
            else       state_next_s = IDLE;
         end
         CONV: begin
            load_s       = 1'b1;
            state_next_s = SHIFT;
         end
         SHIFT: begin
            if (eng_done_s)       state_next_s = DONE;
            else if (!eng_busy_s) state_next_s = IDLE;
            else                  state_next_s = SHIFT;
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Input capture, sign bookkeeping and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc_r     <= '0;
         c_f_r    <= 1'b0;
         neg_r    <= 1'b0;
         mr_nz_r  <= 1'b0;
         ready_r  <= 1'b1;
         done_r   <= 1'b0;
         sign_r   <= 1'b0;
         digits_r <= '0;
         ovf_r    <= 1'b0;
      end else begin
         ready_r <= (state_next_s == IDLE);
         done_r  <= 1'b0;
         if (state_r == IDLE && start) begin
            tc_r  <= tc;
            c_f_r <= c_f;
         end
         if (state_r == CONV) begin
            neg_r   <= neg_s;
            mr_nz_r <= |mr_s;
         end
         if (state_r == DONE) begin
            done_r <= 1'b1;
            sign_r <= neg_r & mr_nz_r;
            ovf_r  <= ovf_s;
            if (ovf_s) digits_r <= {NDIG{4'h9}};
            else       digits_r <= eng_bcd_s[4*NDIG-1:0];
         end
      end
   end

   assign ready  = ready_r;
   assign done   = done_r;
   assign sign   = sign_r;
   assign digits = digits_r;
   assign ovf    = ovf_r;

endmodule

// File: tb/tb_tdisplay_seq.sv
// Scoreboard bench for tdisplay_seq: default 4-digit instance plus a
// 3-digit instance for saturation.
module tb_tdisplay_seq;

   typedef struct {
      logic        sign;
      logic [15:0] digits;
      logic        ovf;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0, start3 = 1'b0;
   logic signed [12:0] tc = '0, tc3 = '0;
   logic               c_f = 1'b0, c_f3 = 1'b0;
   logic               ready, done, sign, ovf;
   logic [15:0]        digits;
   logic               ready3, done3, sign3, ovf3;
   logic [11:0]        digits3;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tdisplay_seq u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tc(tc), .c_f(c_f),
      .ready(ready), .done(done), .sign(sign), .digits(digits), .ovf(ovf)
   );

   tdisplay_seq #(.TC_W(13), .FRAC(4), .NDIG(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .tc(tc3), .c_f(c_f3),
      .ready(ready3), .done(done3), .sign(sign3), .digits(digits3), .ovf(ovf3)
   );

   // Integer reference: tenths, round half away from zero, decimal digits.
   function automatic exp_t model(input int tcv, input bit cf, input int ndig);
      exp_t e;
      int   tx, mag, mr, lim;
      tx  = cf ? tcv * 18 + 320 * 16 : tcv * 10;
      mag = (tx < 0) ? -tx : tx;
      mr  = (mag + 8) / 16;
      lim = (ndig == 3) ? 999 : 9999;
      e.sign   = (tx < 0) && (mr != 0);
      e.ovf    = (mr > lim);
      e.digits = '0;
      if (e.ovf) begin
         for (int i = 0; i < ndig; i++) e.digits[4*i +: 4] = 4'd9;
      end else begin
         for (int i = 0; i < 4; i++) begin
            e.digits[4*i +: 4] = 4'(mr % 10);
            mr = mr / 10;
         end
      end
      return e;
   endfunction

   task automatic pulse(input bit use_b, input int tcv, input bit cf);
      @(negedge clk);
      if (use_b) begin tc3 = 13'(tcv); c_f3 = cf; start3 = 1'b1; end
      else       begin tc  = 13'(tcv); c_f  = cf; start  = 1'b1; end
      @(negedge clk);
      start = 1'b0; start3 = 1'b0;
   endtask

   // Called at the negedge after the start edge; lat = edges until done seen, -1 on timeout.
   task automatic wait_done(input bit use_b, output int lat);
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         if ((use_b ? done3 : done) === 1'b1) begin
            lat = c - 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({ready, done, sign, digits, ovf} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
         errors++;
         $display("FAIL reset_a: got rdy=%b done=%b sign=%b dig=%h ovf=%b want 1 0 0 0000 0",
                  ready, done, sign, digits, ovf);
      end
      checks++;
      if ({ready3, done3, sign3, digits3, ovf3} !== {1'b1, 1'b0, 1'b0, 12'h000, 1'b0}) begin
         errors++;
         $display("FAIL reset_b: got rdy=%b done=%b sign=%b dig=%h ovf=%b want 1 0 0 000 0",
                  ready3, done3, sign3, digits3, ovf3);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_convert();
      int   tcs[9] = '{400, 400, -640, -1, 0, 4095, -4096, -8, 1};
      bit   cfs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int   lat;
      exp_t e;
      for (int i = 0; i < 9; i++) begin
         sbq.push_back(model(tcs[i], cfs[i], 4));
         pulse(1'b0, tcs[i], cfs[i]);
         wait_done(1'b0, lat);
         checks++;
         if (lat !== 15) begin
            errors++;
            $display("FAIL conv_latency[%0d]: got %0d want 15", i, lat);
         end
         e = (sbq.size() > 0) ? sbq.pop_front() : '{1'bx, 16'hxxxx, 1'bx};
         checks++;
         if ({sign, digits, ovf} !== {e.sign, e.digits, e.ovf}) begin
            errors++;
            $display("FAIL conv_result[%0d] tc=%0d cf=%b: got sign=%b dig=%h ovf=%b want sign=%b dig=%h ovf=%b",
                     i, tcs[i], cfs[i], sign, digits, ovf, e.sign, e.digits, e.ovf);
         end
         checks++;
         if (ready !== 1'b1) begin
            errors++;
            $display("FAIL conv_ready[%0d]: got %b want 1", i, ready);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL conv_done_pulse[%0d]: done still %b want 0", i, done);
         end
      end
   endtask

   task automatic test_overflow();
      int   tcs[3] = '{4095, 16, -4096};
      bit   cfs[3] = '{1'b0, 1'b0, 1'b1};
      int   lat;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         sbq.push_back(model(tcs[i], cfs[i], 3));
         pulse(1'b1, tcs[i], cfs[i]);
         wait_done(1'b1, lat);
         checks++;
         if (lat !== 15) begin
            errors++;
            $display("FAIL ovf_latency[%0d]: got %0d want 15", i, lat);
         end
         e = (sbq.size() > 0) ? sbq.pop_front() : '{1'bx, 16'hxxxx, 1'bx};
         checks++;
         if ({sign3, digits3, ovf3} !== {e.sign, e.digits[11:0], e.ovf}) begin
            errors++;
            $display("FAIL ovf_result[%0d] tc=%0d: got sign=%b dig=%h ovf=%b want sign=%b dig=%h ovf=%b",
                     i, tcs[i], sign3, digits3, ovf3, e.sign, e.digits[11:0], e.ovf);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int   lat, extra;
      exp_t e;
      sbq.push_back(model(400, 1'b0, 4));
      pulse(1'b0, 400, 1'b0);
      repeat (5) @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_ready: got %b want 0", ready);
      end
      tc = 13'sd1234; c_f = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b0, lat);
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL busy_latency: got %0d want 9 edges after the ignored start", lat);
      end
      e = (sbq.size() > 0) ? sbq.pop_front() : '{1'bx, 16'hxxxx, 1'bx};
      checks++;
      if ({sign, digits, ovf} !== {e.sign, e.digits, e.ovf}) begin
         errors++;
         $display("FAIL busy_result: got sign=%b dig=%h ovf=%b want sign=%b dig=%h ovf=%b",
                  sign, digits, ovf, e.sign, e.digits, e.ovf);
      end
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL busy_no_queue: got %0d extra done pulses want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int   vals[3] = '{100, -250, 3000};
      int   stamp[3];
      int   n, cyc;
      exp_t e;
      n = 0; cyc = 0;
      @(negedge clk);
      sbq.push_back(model(vals[0], 1'b0, 4));
      tc = 13'(vals[0]); c_f = 1'b0; start = 1'b1;
      while (n < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) begin
            stamp[n] = cyc;
            e = (sbq.size() > 0) ? sbq.pop_front() : '{1'bx, 16'hxxxx, 1'bx};
            checks++;
            if ({sign, digits, ovf} !== {e.sign, e.digits, e.ovf}) begin
               errors++;
               $display("FAIL b2b_result[%0d]: got sign=%b dig=%h ovf=%b want sign=%b dig=%h ovf=%b",
                        n, sign, digits, ovf, e.sign, e.digits, e.ovf);
            end
            n++;
            if (n < 3) begin
               tc = 13'(vals[n]);
               sbq.push_back(model(vals[n], 1'b0, 4));
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d done pulses want 3", n);
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (stamp[i] - stamp[i-1] !== 16) begin
               errors++;
               $display("FAIL b2b_period[%0d]: got %0d want 16", i, stamp[i] - stamp[i-1]);
            end
         end
      end
   endtask

   task automatic test_reset_abort();
      int   lat, extra;
      exp_t e;
      pulse(1'b0, 1000, 1'b0);
      repeat (6) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready, done, sign, digits, ovf} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
         errors++;
         $display("FAIL abort_outputs: got rdy=%b done=%b sign=%b dig=%h ovf=%b want 1 0 0 0000 0",
                  ready, done, sign, digits, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done pulses want 0", extra);
      end
      sbq.push_back(model(-37, 1'b1, 4));
      pulse(1'b0, -37, 1'b1);
      wait_done(1'b0, lat);
      checks++;
      if (lat !== 15) begin
         errors++;
         $display("FAIL abort_fresh_latency: got %0d want 15", lat);
      end
      e = (sbq.size() > 0) ? sbq.pop_front() : '{1'bx, 16'hxxxx, 1'bx};
      checks++;
      if ({sign, digits, ovf} !== {e.sign, e.digits, e.ovf}) begin
         errors++;
         $display("FAIL abort_fresh_result: got sign=%b dig=%h ovf=%b want sign=%b dig=%h ovf=%b",
                  sign, digits, ovf, e.sign, e.digits, e.ovf);
      end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_overflow();
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
